// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM encoding,
// default parameter values and hold-counter width.
package bus_arb_pkg;

  localparam int          NUM_OF_MASTER_DEF   = 16;
  localparam int          NUM_OF_SEL_BITS_DEF = 4;
  localparam logic [7:0]  MAX_HOLD_DEF        = 8'd200;
  localparam int          HOLD_CNT_W          = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_TURN = 2'd2;

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational round-robin search: first asserted request strictly after
// the previous owner, wrapping modulo the number of masters.
module arb_rr_picker
  import bus_arb_pkg::*;
#(
  parameter int NUM_OF_MASTER   = NUM_OF_MASTER_DEF,
  parameter int NUM_OF_SEL_BITS = NUM_OF_SEL_BITS_DEF
) (
  input  logic [NUM_OF_MASTER-1:0]   req_i,
  input  logic [NUM_OF_SEL_BITS-1:0] last_i,
  output logic [NUM_OF_SEL_BITS-1:0] win_o,
  output logic                       valid_o
);

  logic [NUM_OF_SEL_BITS-1:0] idx;

  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    // Offset 1..N so the previous owner is examined last.
    for (int k = 1; k <= NUM_OF_MASTER; k++) begin
      idx = NUM_OF_SEL_BITS'((int'(last_i) + k) % NUM_OF_MASTER);
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        win_o   = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with bounded ownership (IDLE/OWN/TURN FSM).
// All outputs come straight from registers.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int         NUM_OF_MASTER   = NUM_OF_MASTER_DEF,
  parameter int         NUM_OF_SEL_BITS = NUM_OF_SEL_BITS_DEF,
  parameter logic [7:0] MAX_HOLD        = MAX_HOLD_DEF
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NUM_OF_MASTER-1:0]   REQ,
  input  logic                       DONE,
  output logic [NUM_OF_MASTER-1:0]   GNT,
  output logic [NUM_OF_SEL_BITS-1:0] SEL,
  output logic                       BUSY,
  output logic                       TIMEOUT,
  output logic [1:0]                 dbg_state_o
);

  logic [1:0]                 state_q, state_d;
  logic [HOLD_CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_OF_SEL_BITS-1:0] last_q, last_d;
  logic [NUM_OF_MASTER-1:0]   gnt_q, gnt_d;
  logic [NUM_OF_SEL_BITS-1:0] sel_q, sel_d;
  logic                       busy_q, busy_d;
  logic                       timeout_q, timeout_d;

  logic [NUM_OF_SEL_BITS-1:0] pick_idx;
  logic                       pick_valid;
  logic                       rel_normal;
  logic                       at_limit;

  arb_rr_picker #(
    .NUM_OF_MASTER  (NUM_OF_MASTER),
    .NUM_OF_SEL_BITS(NUM_OF_SEL_BITS)
  ) u_picker (
    .req_i  (REQ),
    .last_i (last_q),
    .win_o  (pick_idx),
    .valid_o(pick_valid)
  );

  // A normal release (DONE or owner dropped REQ) always masks the timeout.
  assign rel_normal = DONE || !REQ[sel_q];
  assign at_limit   = (cnt_q == (MAX_HOLD - 8'd1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_TURN: begin
        if (pick_valid) begin
          state_d         = ST_OWN;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          sel_d           = pick_idx;
          last_d          = pick_idx;
          busy_d          = 1'b1;
          cnt_d           = '0;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      ST_OWN: begin
        if (rel_normal || at_limit) begin
          state_d   = ST_TURN;
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = !rel_normal;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= NUM_OF_SEL_BITS'(NUM_OF_MASTER - 1);
      gnt_q     <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign GNT         = gnt_q;
  assign SEL         = sel_q;
  assign BUSY        = busy_q;
  assign TIMEOUT     = timeout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter (MAX_HOLD = 4): behavioural model feeding an
// expected queue, directed scenarios with fixed expectations, random soak.
module tb_bus_arbiter;

  localparam int         N  = 16;
  localparam int         SB = 4;
  localparam logic [7:0] MH = 8'd4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          done;
  logic [N-1:0]  gnt;
  logic [SB-1:0] sel;
  logic          busy;
  logic          timeout;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  // Packed expected output: {gnt, sel, busy, timeout}
  logic [N+SB+1:0] exp_q[$];

  // Behavioural reference state
  int           m_state;
  int           m_cnt;
  int           m_last;
  logic [N-1:0] m_gnt;
  int           m_sel;
  logic         m_busy;
  logic         m_to;

  bus_arbiter #(
    .NUM_OF_MASTER  (N),
    .NUM_OF_SEL_BITS(SB),
    .MAX_HOLD       (MH)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .REQ        (req),
    .DONE       (done),
    .GNT        (gnt),
    .SEL        (sel),
    .BUSY       (busy),
    .TIMEOUT    (timeout),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run time limit expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic d, input logic rn);
    int  w;
    int  j;
    logic norm;
    if (!rn) begin
      m_state = 0; m_cnt = 0; m_last = N - 1;
      m_gnt = '0; m_sel = 0; m_busy = 1'b0; m_to = 1'b0;
    end else if (m_state == 1) begin
      norm = d || !r[m_sel];
      if (norm || (m_cnt == int'(MH) - 1)) begin
        m_state = 2; m_gnt = '0; m_busy = 1'b0; m_to = !norm;
      end else begin
        m_cnt++; m_to = 1'b0;
      end
    end else begin
      m_to = 1'b0;
      w = -1;
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (w < 0 && r[j]) w = j;
      end
      if (w >= 0) begin
        m_state = 1; m_gnt = '0; m_gnt[w] = 1'b1; m_sel = w; m_last = w;
        m_busy = 1'b1; m_cnt = 0;
      end else begin
        m_state = 0; m_gnt = '0; m_busy = 1'b0;
      end
    end
  endtask

  // One clock: drive inputs, push expectation, sample after the edge, compare.
  task automatic drive(input logic [N-1:0] r, input logic d, input logic rn);
    logic [N+SB+1:0] exp_v;
    logic [N+SB+1:0] obs_v;
    @(negedge clk);
    req   = r;
    done  = d;
    rst_n = rn;
    model_step(r, d, rn);
    exp_q.push_back({m_gnt, SB'(m_sel), m_busy, m_to});
    @(posedge clk);
    #1;
    obs_v = {gnt, sel, busy, timeout};
    exp_v = exp_q.pop_front();
    check_eq("model", 32'(obs_v), 32'(exp_v));
  endtask

  task automatic check_outs(input string tag, input logic [N-1:0] eg, input int es,
                            input logic eb, input logic et);
    check_eq({tag, "_gnt"}, 32'(gnt), 32'(eg));
    check_eq({tag, "_sel"}, 32'(sel), 32'(es));
    check_eq({tag, "_busy"}, 32'(busy), 32'(eb));
    check_eq({tag, "_timeout"}, 32'(timeout), 32'(et));
  endtask

  int           order[4] = '{0, 7, 15, 0};
  int           wait_cnt[N];
  logic         prev_busy;
  logic [N-1:0] req_r;
  logic         rn_r;
  int           gidx;

  initial begin
    // Reset state
    drive('0, 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0);
    check_outs("reset", '0, 0, 1'b0, 1'b0);

    // Single requester: grant one cycle after REQ is first sampled
    drive(16'h0001, 1'b0, 1'b1);
    check_outs("first_grant", 16'h0001, 0, 1'b1, 1'b0);
    drive(16'h0001, 1'b0, 1'b1);
    drive(16'h0001, 1'b0, 1'b1);
    drive(16'h0000, 1'b0, 1'b1);
    check_outs("req_drop", '0, 0, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b1);

    // Round-robin order 0,7,15,0 with DONE two cycles into each grant
    drive('0, 1'b0, 1'b0);
    for (int g = 0; g < 4; g++) begin
      drive(16'h8081, 1'b0, 1'b1);
      check_outs("rr_grant", 16'(1 << order[g]), order[g], 1'b1, 1'b0);
      drive(16'h8081, 1'b0, 1'b1);
      drive(16'h8081, 1'b1, 1'b1);
      check_outs("rr_turn", '0, order[g], 1'b0, 1'b0);
    end
    drive('0, 1'b0, 1'b1);

    // Hold limit: 4 ownership cycles then timeout, then re-grant to 3
    drive('0, 1'b0, 1'b0);
    drive(16'h0008, 1'b0, 1'b1);
    check_outs("hold_grant", 16'h0008, 3, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(16'h0008, 1'b0, 1'b1);
      check_outs("hold_own", 16'h0008, 3, 1'b1, 1'b0);
    end
    drive(16'h0008, 1'b0, 1'b1);
    check_outs("hold_timeout", '0, 3, 1'b0, 1'b1);
    drive(16'h0008, 1'b0, 1'b1);
    check_outs("hold_regrant", 16'h0008, 3, 1'b1, 1'b0);

    // DONE in the 4th ownership cycle masks the timeout
    for (int k = 0; k < 3; k++) drive(16'h0008, 1'b0, 1'b1);
    drive(16'h0008, 1'b1, 1'b1);
    check_outs("limit_done", '0, 3, 1'b0, 1'b0);
    // REQ dropped in the 4th ownership cycle also masks it
    drive(16'h0008, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) drive(16'h0008, 1'b0, 1'b1);
    drive(16'h0000, 1'b0, 1'b1);
    check_outs("limit_drop", '0, 3, 1'b0, 1'b0);
    drive('0, 1'b0, 1'b1);

    // Reset during ownership of master 5, then master 0 wins first
    drive('0, 1'b0, 1'b0);
    drive(16'h0020, 1'b0, 1'b1);
    check_outs("own5", 16'h0020, 5, 1'b1, 1'b0);
    drive(16'h0021, 1'b0, 1'b0);
    check_outs("own5_reset", '0, 0, 1'b0, 1'b0);
    drive(16'h0021, 1'b0, 1'b1);
    check_outs("post_reset", 16'h0001, 0, 1'b1, 1'b0);

    // Random soak with sticky requests
    drive('0, 1'b0, 1'b0);
    req_r     = '0;
    prev_busy = 1'b0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(11) == 0) req_r[i] = ~req_r[i];
      rn_r = ($urandom_range(1999) != 0);
      drive(req_r, ($urandom_range(3) == 0), rn_r);
      check_eq("onehot0", 32'($onehot0(gnt)), 32'd1);
      if (busy) begin
        gidx = -1;
        for (int i = 0; i < N; i++) if (gnt[i]) gidx = i;
        check_eq("sel_idx", 32'(sel), 32'(gidx));
      end
      for (int i = 0; i < N; i++) begin
        if (!rn_r || !req_r[i]) wait_cnt[i] = 0;
        else if (busy && !prev_busy) begin
          if (gnt[i]) wait_cnt[i] = 0;
          else wait_cnt[i]++;
        end
      end
      if (busy && !prev_busy) begin
        gidx = 0;
        for (int i = 0; i < N; i++) if (wait_cnt[i] > gidx) gidx = wait_cnt[i];
        check_eq("starve", 32'(gidx <= 15), 32'd1);
      end
      prev_busy = busy;
    end

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_OF_MASTER, default 16, SHALL be the number of requesting masters.
REQ-002 Parameter NUM_OF_SEL_BITS, default 4, SHALL be ceil(log2(NUM_OF_MASTER)).
REQ-003 Parameter MAX_HOLD, default 8'd200, range 1..255, SHALL be the maximum number of ownership cycles per grant.
REQ-004 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 RST_N  input  1  SHALL be the reset: synchronous, active-low.
REQ-006 REQ  input  NUM_OF_MASTER  SHALL carry per-master bus requests, level-sensitive.
REQ-007 DONE  input  1  SHALL signal that the current owner finished its transfer; one-cycle pulse.
REQ-008 GNT  output  NUM_OF_MASTER  SHALL be the registered, one-hot-or-zero grant vector.
REQ-009 SEL  output  NUM_OF_SEL_BITS  SHALL be the registered index of the current or last owner, driving the downstream multiplexer SEL.
REQ-010 BUSY  output  1  SHALL be high exactly while a grant is active.
REQ-011 TIMEOUT  output  1  SHALL pulse high for one cycle on a forced release.

Function
REQ-012 The FSM SHALL have the states IDLE, OWN and TURN.
REQ-013 In IDLE or TURN with |REQ = 1, the block SHALL enter OWN next cycle with GNT one-hot at the winner, SEL = winner index, BUSY = 1 (grant latency 1 cycle).
REQ-014 In IDLE or TURN with REQ = 0, the block SHALL go to or stay in IDLE with GNT = 0 and BUSY = 0.
REQ-015 Winner selection SHALL be round-robin: first asserted REQ at index LAST+1, LAST+2, … with wrap modulo NUM_OF_MASTER, where LAST is the previous owner.
REQ-016 LAST SHALL update to the winner on every grant.
REQ-017 In OWN, the 8-bit hold counter SHALL start at 0 on grant and increment each cycle.
REQ-018 Release SHALL occur when DONE = 1, when REQ[SEL] = 0, or when the counter equals MAX_HOLD-1; the next state SHALL be TURN with GNT = 0 and BUSY = 0.
REQ-019 TIMEOUT SHALL assert only when release is caused solely by the counter.
REQ-020 If DONE or a dropped REQ coincides with the counter limit, the release SHALL be normal with TIMEOUT = 0.
REQ-021 TURN SHALL last exactly one cycle, giving a minimum one-cycle dead gap between consecutive grants.
REQ-022 SEL SHALL hold its value through TURN and IDLE; it changes only on a new grant.
REQ-023 Requests from non-owners during OWN SHALL be ignored until TURN; there is no preemption.
REQ-024 With only one requester holding REQ continuously, that requester SHALL be re-granted after each TURN.
REQ-025 GNT SHALL never have more than one bit set.

Reset
REQ-026 On a rising CLK edge with RST_N = 0, the outputs SHALL reset to GNT = 0, SEL = 0, BUSY = 0 and TIMEOUT = 0.
REQ-027 The same reset SHALL set the internal state to FSM = IDLE, counter = 0 and LAST = NUM_OF_MASTER-1, so master 0 has first priority.
REQ-028 Reset asserted during OWN SHALL abort the grant immediately at that edge; no TURN cycle SHALL follow.
REQ-029 Arbitration SHALL resume on the first edge with RST_N = 1.

Structure
REQ-030 The shared package bus_arb_pkg SHALL hold the state encoding (IDLE, OWN, TURN), the default parameter values and the hold-counter width.
REQ-031 The round-robin priority search SHALL be a combinational sub-module arb_rr_picker (inputs REQ and LAST; outputs winner index and a valid flag), instantiated once.
REQ-032 All outputs SHALL be driven directly from registers.

Verification
REQ-033 Reset, then REQ = 16'h0001 for 3 cycles -> GNT = 16'h0001, SEL = 0, BUSY = 1 one cycle after REQ first sampled.
REQ-034 REQ = 16'h8081 held with DONE pulsed 2 cycles into each grant -> grant order 0, 7, 15, 0, with one TURN cycle between grants.
REQ-035 MAX_HOLD = 4, REQ[3] held, no DONE -> BUSY high for exactly 4 cycles, TIMEOUT pulse on the release edge, then re-grant to 3 after TURN.
REQ-036 MAX_HOLD = 4, DONE asserted in the 4th ownership cycle -> release with TIMEOUT = 0.
REQ-037 Owner 5 active, RST_N = 0 for one cycle -> GNT = 0, SEL = 0, BUSY = 0 at that edge; with REQ = 16'h0021 held afterward, the next grant goes to master 0.
REQ-038 Random REQ/DONE for 10k cycles -> GNT always one-hot-or-zero, SEL == index of the GNT bit whenever BUSY = 1, and no REQ bit held continuously waits more than 15 grants.
